// File: rtl/base_dispatch.sv
// In-order issue queue between decode stage2 and the base execution unit.
// Head entry drives the EU combinationally; the EU result is captured in a writeback register.
module base_dispatch #(
   parameter int DEPTH = 4,
   parameter int SEL_W = 6,
   parameter int TAG_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [SEL_W-1:0] in_select,
   input  logic [63:0]      in_op1,
   input  logic [63:0]      in_op2,
   input  logic [TAG_W-1:0] in_rd,
   output logic [SEL_W-1:0] eu_select,
   output logic [63:0]      eu_op1,
   output logic [63:0]      eu_op2,
   input  logic [63:0]      eu_result,
   output logic             wb_valid,
   input  logic             wb_ready,
   output logic [63:0]      wb_result,
   output logic [TAG_W-1:0] wb_rd
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);
   localparam logic [PTR_W-1:0] PINC_C  = PTR_W'(1);

   logic [SEL_W-1:0] sel_mem_r [DEPTH];
   logic [63:0]      op1_mem_r [DEPTH];
   logic [63:0]      op2_mem_r [DEPTH];
   logic [TAG_W-1:0] rd_mem_r  [DEPTH];

   logic [PTR_W-1:0] wr_ptr_r;
   logic [PTR_W-1:0] rd_ptr_r;
   logic [CNT_W-1:0] count_r;

   logic             not_empty_s;
   logic             push_s;
   logic             issue_s;
   logic             drain_s;

   // Handshake decode; flush blocks both queue operations.
   always_comb begin
      not_empty_s = (count_r != {CNT_W{1'b0}});
      in_ready    = (count_r < DEPTH_C);
      push_s      = in_valid && in_ready && !flush;
      issue_s     = not_empty_s && (!wb_valid || wb_ready) && !flush;
      drain_s     = wb_valid && wb_ready;
   end

   // Present the head entry to the EU, or a NOP when the queue is empty.
   always_comb begin
      eu_select = {SEL_W{1'b0}};
      eu_op1    = 64'd0;
      eu_op2    = 64'd0;
      if (not_empty_s) begin
         eu_select = sel_mem_r[rd_ptr_r];
         eu_op1    = op1_mem_r[rd_ptr_r];
         eu_op2    = op2_mem_r[rd_ptr_r];
      end else begin
         eu_select = {SEL_W{1'b0}};
         eu_op1    = 64'd0;
         eu_op2    = 64'd0;
      end
   end

   // Entry storage; contents are not reset since count qualifies every read.
   always_ff @(posedge clk) begin
      if (push_s) begin
         sel_mem_r[wr_ptr_r] <= in_select;
         op1_mem_r[wr_ptr_r] <= in_op1;
         op2_mem_r[wr_ptr_r] <= in_op2;
         rd_mem_r[wr_ptr_r]  <= in_rd;
      end
   end

   // Pointers and occupancy count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
         count_r  <= {CNT_W{1'b0}};
      end else if (flush) begin
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
         count_r  <= {CNT_W{1'b0}};
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PINC_C;
         end
         if (issue_s) begin
            rd_ptr_r <= rd_ptr_r + PINC_C;
         end
         case ({push_s, issue_s})
            2'b10:   count_r <= count_r + ONE_C;
            2'b01:   count_r <= count_r - ONE_C;
            default: count_r <= count_r;
         endcase
      end
   end

   // Writeback register: load on issue, clear valid on drain, hold while stalled.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wb_valid  <= 1'b0;
         wb_result <= 64'd0;
         wb_rd     <= {TAG_W{1'b0}};
      end else if (flush) begin
         wb_valid  <= 1'b0;
      end else if (issue_s) begin
         wb_valid  <= 1'b1;
         wb_result <= eu_result;
         wb_rd     <= rd_mem_r[rd_ptr_r];
      end else if (drain_s) begin
         wb_valid  <= 1'b0;
      end else begin
         wb_valid  <= wb_valid;
      end
   end

endmodule

// File: tb/tb_base_dispatch.sv
// Scoreboard bench for base_dispatch: accepted pushes queue expected results,
// writeback outputs are compared against the queue head.
module tb_base_dispatch;
   localparam int DEPTH = 4;
   localparam int SEL_W = 6;
   localparam int TAG_W = 5;
   localparam logic [SEL_W-1:0] OP_ADD = 6'd1;
   localparam logic [SEL_W-1:0] OP_SUB = 6'd2;
   localparam logic [SEL_W-1:0] OP_XOR = 6'd3;

   logic             clk = 1'b0;
   logic             rst, flush, in_valid, in_ready, wb_valid, wb_ready;
   logic [SEL_W-1:0] in_select, eu_select;
   logic [63:0]      in_op1, in_op2, eu_op1, eu_op2, eu_result, wb_result;
   logic [TAG_W-1:0] in_rd, wb_rd;

   typedef struct {
      logic [SEL_W-1:0] sel;
      logic [63:0]      op1;
      logic [63:0]      op2;
      logic [TAG_W-1:0] rd;
      logic [63:0]      res;
   } ent_t;

   ent_t exp_q[$];
   int   m_cnt;
   bit   m_wbv;
   int   n_cmp = 0;
   int   n_err = 0;

   base_dispatch #(.DEPTH(DEPTH), .SEL_W(SEL_W), .TAG_W(TAG_W)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_select(in_select),
      .in_op1(in_op1), .in_op2(in_op2), .in_rd(in_rd),
      .eu_select(eu_select), .eu_op1(eu_op1), .eu_op2(eu_op2), .eu_result(eu_result),
      .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_result(wb_result), .wb_rd(wb_rd)
   );

   always #5 clk = ~clk;

   function automatic logic [63:0] ref_alu(input logic [SEL_W-1:0] s, input logic [63:0] a, input logic [63:0] b);
      case (s)
         OP_ADD:  return a + b;
         OP_SUB:  return a - b;
         OP_XOR:  return a ^ b;
         default: return 64'd0;
      endcase
   endfunction

   // Stand-in for the base EU.
   always_comb eu_result = ref_alu(eu_select, eu_op1, eu_op2);

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_cmp++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h at %0t", tag, got, want, $time);
      end
   endtask

   task automatic set_in(input bit v, input logic [SEL_W-1:0] s, input logic [63:0] a,
                         input logic [63:0] b, input logic [TAG_W-1:0] r);
      in_valid = v; in_select = s; in_op1 = a; in_op2 = b; in_rd = r;
   endtask

   // One clock: check pre-edge outputs, advance the model, clock, check post-edge.
   task automatic cycle();
      ent_t e;
      bit   push, issue, drain;
      int   hidx;
      if (m_wbv) begin
         chk("wb_valid_hold", {63'd0, wb_valid}, 64'd1);
         if (exp_q.size() > 0) begin
            chk("wb_result", wb_result, exp_q[0].res);
            chk("wb_rd", {59'd0, wb_rd}, {59'd0, exp_q[0].rd});
         end
      end
      hidx = m_wbv ? 1 : 0;
      if (m_cnt > 0 && exp_q.size() > hidx) begin
         chk("eu_select", {58'd0, eu_select}, {58'd0, exp_q[hidx].sel});
         chk("eu_op1", eu_op1, exp_q[hidx].op1);
         chk("eu_op2", eu_op2, exp_q[hidx].op2);
      end else if (m_cnt == 0) begin
         chk("eu_nop_sel", {58'd0, eu_select}, 64'd0);
         chk("eu_nop_op1", eu_op1, 64'd0);
      end
      push  = in_valid && (m_cnt < DEPTH) && !flush;
      issue = (m_cnt > 0) && (!m_wbv || wb_ready) && !flush;
      drain = m_wbv && wb_ready;
      if (flush) begin
         exp_q.delete();
         m_cnt = 0;
         m_wbv = 1'b0;
      end else begin
         if (drain && exp_q.size() > 0) void'(exp_q.pop_front());
         if (push) begin
            e.sel = in_select; e.op1 = in_op1; e.op2 = in_op2; e.rd = in_rd;
            e.res = ref_alu(in_select, in_op1, in_op2);
            exp_q.push_back(e);
         end
         m_cnt = m_cnt + int'(push) - int'(issue);
         if (issue) m_wbv = 1'b1;
         else if (drain) m_wbv = 1'b0;
      end
      @(posedge clk);
      #1;
      chk("in_ready", {63'd0, in_ready}, {63'd0, (m_cnt < DEPTH)});
      chk("wb_valid", {63'd0, wb_valid}, {63'd0, m_wbv});
   endtask

   task automatic drain_all(input string tag);
      int n = 0;
      wb_ready = 1'b1;
      set_in(1'b0, 6'd0, 64'd0, 64'd0, 5'd0);
      while ((exp_q.size() > 0 || m_wbv) && n < 40) begin
         cycle();
         n++;
      end
      chk(tag, 64'(exp_q.size()), 64'd0);
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; wb_ready = 1'b1;
      set_in(1'b0, 6'd0, 64'd0, 64'd0, 5'd0);
      m_cnt = 0; m_wbv = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
      chk("rst_wb_valid", {63'd0, wb_valid}, 64'd0);
      chk("rst_wb_result", wb_result, 64'd0);
      chk("rst_wb_rd", {59'd0, wb_rd}, 64'd0);
      chk("rst_eu_select", {58'd0, eu_select}, 64'd0);
      rst = 1'b0;
      cycle();

      // Single ADD: 5 + 7 to rd 3, valid for exactly one cycle.
      set_in(1'b1, OP_ADD, 64'd5, 64'd7, 5'd3);
      cycle();
      set_in(1'b0, 6'd0, 64'd0, 64'd0, 5'd0);
      chk("add_eu_op1", eu_op1, 64'd5);
      chk("add_eu_op2", eu_op2, 64'd7);
      cycle();
      chk("add_wb_result", wb_result, 64'd12);
      chk("add_wb_rd", {59'd0, wb_rd}, 64'd3);
      cycle();
      chk("add_one_shot", {63'd0, wb_valid}, 64'd0);

      // Fill under backpressure; 6th push refused, stall holds outputs.
      wb_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         set_in(1'b1, OP_XOR, 64'(i * 3 + 1), 64'h0f0f, 5'(i + 1));
         cycle();
      end
      chk("fill_in_ready", {63'd0, in_ready}, 64'd0);
      set_in(1'b0, 6'd0, 64'd0, 64'd0, 5'd0);
      repeat (3) cycle();
      chk("stall_wb_rd", {59'd0, wb_rd}, 64'd1);
      drain_all("fill_drain");

      // Stream of 16 SUBs, all results 10, pointers wrap.
      wb_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         set_in(1'b1, OP_SUB, 64'(i + 10), 64'(i), 5'(i));
         cycle();
         chk("stream_ready", {63'd0, in_ready}, 64'd1);
      end
      drain_all("stream_drain");

      // Flush with 3 queued plus a pending writeback, together with a push.
      wb_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         set_in(1'b1, OP_ADD, 64'(100 + i), 64'd1, 5'(20 + i));
         cycle();
      end
      flush = 1'b1;
      set_in(1'b1, OP_ADD, 64'd999, 64'd1, 5'd31);
      cycle();
      flush = 1'b0;
      set_in(1'b0, 6'd0, 64'd0, 64'd0, 5'd0);
      chk("flush_wb_valid", {63'd0, wb_valid}, 64'd0);
      chk("flush_in_ready", {63'd0, in_ready}, 64'd1);
      chk("flush_eu_sel", {58'd0, eu_select}, 64'd0);
      wb_ready = 1'b1;
      repeat (2) cycle();

      // Async reset between edges with 2 ops queued behind a pending writeback.
      wb_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         set_in(1'b1, OP_SUB, 64'(50 + i), 64'd5, 5'(10 + i));
         cycle();
      end
      set_in(1'b0, 6'd0, 64'd0, 64'd0, 5'd0);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_wb_valid", {63'd0, wb_valid}, 64'd0);
      chk("arst_in_ready", {63'd0, in_ready}, 64'd1);
      chk("arst_eu_sel", {58'd0, eu_select}, 64'd0);
      chk("arst_wb_result", wb_result, 64'd0);
      exp_q.delete(); m_cnt = 0; m_wbv = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      wb_ready = 1'b1;
      set_in(1'b1, OP_ADD, 64'd40, 64'd2, 5'd7);
      cycle();
      drain_all("arst_drain");

      // Random traffic with occasional flush.
      for (int i = 0; i < 300; i++) begin
         wb_ready = ($urandom_range(0, 3) != 0);
         flush    = ($urandom_range(0, 40) == 0);
         set_in($urandom_range(0, 2) != 0, 6'($urandom_range(1, 3)),
                {$urandom, $urandom}, {$urandom, $urandom}, 5'($urandom_range(0, 31)));
         cycle();
      end
      flush = 1'b0;
      drain_all("rand_drain");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/base_dispatch.md
BASE_DISPATCH -- requirements
Module: base_dispatch

Interface
REQ-001 Parameter DEPTH, default 4: issue queue entries; power of two and at least 2.
REQ-002 Parameter SEL_W, default 6: width of the operation select code from instr_op.sv.
REQ-003 Parameter TAG_W, default 5: width of the destination register tag.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 flush  input  1  synchronous pipeline flush.
REQ-007 in_valid  input  1  stage2 presents a decoded operation.
REQ-008 in_ready  output  1  queue can accept an operation.
REQ-009 in_select  input  SEL_W  operation code.
REQ-010 in_op1, in_op2  input  64 each  operands (op1 = pc for AUIPC).
REQ-011 in_rd  input  TAG_W  destination tag.
REQ-012 eu_select  output  SEL_W  to base EU.
REQ-013 eu_op1, eu_op2  output  64 each  to base EU.
REQ-014 eu_result  input  64  combinational result from base EU.
REQ-015 wb_valid  output  1  writeback result is valid.
REQ-016 wb_ready  input  1  writeback stage accepts the result.
REQ-017 wb_result  output  64  registered EU result.
REQ-018 wb_rd  output  TAG_W  tag of wb_result.

Function
REQ-019 Push occurs when in_valid && in_ready && !flush; {select, op1, op2, rd} is written at the write pointer.
REQ-020 in_ready SHALL be 1 exactly when count < DEPTH; it has no combinational dependence on wb_ready.
REQ-021 While count > 0, eu_select/eu_op1/eu_op2 SHALL equal the head entry combinationally from storage; while count == 0 they are 0 (select 0 = NOP).
REQ-022 Issue occurs when count > 0 && (!wb_valid || wb_ready) && !flush.
REQ-023 On issue: wb_result <= eu_result, wb_rd <= head rd, wb_valid <= 1, read pointer advances.
REQ-024 When wb_valid && wb_ready without issue: wb_valid <= 0 and wb_result/wb_rd hold their values.
REQ-025 When wb_valid && !wb_ready: wb_valid, wb_result and wb_rd hold their values unchanged (stall).
REQ-026 Pointers are log2(DEPTH) bits and wrap from DEPTH-1 to 0; count is log2(DEPTH)+1 bits.
REQ-027 Push and issue in the same cycle leave count unchanged; a full queue accepts no push even when issuing that cycle.
REQ-028 Empty queue: no issue; a push into an empty queue is issuable no earlier than the following cycle (no bypass).
REQ-029 Latency: an operation pushed at edge N appears on wb_valid/wb_result after edge N+1 when unstalled; throughput is 1 op per cycle.
REQ-030 Ordering: results SHALL leave in push order; no entry is dropped or duplicated.
REQ-031 flush has priority over push and issue: at the edge, count, pointers and wb_valid are cleared; queue contents and wb_result may retain stale data.

Reset
REQ-032 On rst assertion, asynchronously: count = 0, both pointers = 0, wb_valid = 0, wb_result = 0, wb_rd = 0.
REQ-033 Consequently, during reset in_ready = 1 and eu_select/eu_op1/eu_op2 = 0.
REQ-034 Reset mid-operation discards all queued and pending results; the first push after deassertion behaves as on an empty queue.

Verification
REQ-035 Single ADD: push select=ADD, op1=5, op2=7, rd=3 with wb_ready=1 -> one cycle later eu_op1=5, eu_op2=7; next cycle wb_valid=1, wb_result=12, wb_rd=3, for exactly one cycle.
REQ-036 Fill/backpressure: wb_ready=0, push 5 ops -> first issues to wb, next 4 fill queue, in_ready=0; a 6th push is refused; raising wb_ready drains 5 results in order, one per cycle.
REQ-037 Stream: continuous push of 16 SUB ops (op1=i+10, op2=i), wb_ready=1 -> 16 results all equal 10, in order, in_ready constantly 1, pointers wrap 4 times.
REQ-038 Stall hold: wb_ready=0 for 3 cycles with wb_valid=1 -> wb_result/wb_rd stable; queue head unchanged.
REQ-039 Flush: 3 queued plus wb_valid=1, assert flush together with in_valid -> next cycle count=0, wb_valid=0, in_ready=1, no push recorded.
REQ-040 Async reset: assert rst between edges while 2 ops are queued -> wb_valid and in_ready-related state cleared immediately, before the next clock edge.
